fetch: RTL
==========

// Module: fetch
// PURPOSE
//  Instruction-fetch stage of the in-order core. Sits directly upstream of decode.
//  - Owns the fetch PC and issues one instruction-memory request at a time over a req/ready + rvalid handshake.
//  - Drives the IF/ID pipeline register (pc_o, inst, inst_valid_o) that decode consumes.
//  - Takes redirects from decode's pcsel/branch_tar. Holds on StallFetch_i.
// PARAMETERS
//  WIDTH     32            instruction/data width
//  ADDR_LEN  32            PC / address width
//  RESET_PC  32'h0000_0000 first fetch address after reset
//  NOP_INST  32'h0000_0013 bubble encoding (addi x0,x0,0)
// PORTS
//  clk           in   1         single clock
//  reset         in   1         synchronous, active-high reset
//  pcsel         in   2         from decode: PC_PLUS4=2'b00, PC_BRANCH=2'b01 (others = PLUS4)
//  branch_tar    in   ADDR_LEN  redirect target, valid when pcsel==PC_BRANCH
//  StallFetch_i  in   1         hold IF/ID and ignore redirect this cycle
//  imem_req_o    out  1         request valid
//  imem_addr_o   out  ADDR_LEN  request address (= fetch PC)
//  imem_ready_i  in   1         request accepted when req&ready
//  imem_rvalid_i in   1         response valid (exactly one per accepted req, >=1 cycle later)
//  imem_rdata_i  in   WIDTH     response instruction
//  pc_o          out  ADDR_LEN  IF/ID: PC of inst
//  inst          out  WIDTH     IF/ID: instruction (NOP_INST when bubble)
//  inst_valid_o  out  1         IF/ID: 1 = real instruction
// BEHAVIOUR
//  Reset (sync): pc_f=RESET_PC, state=S_REQ, kill=0, skid empty; pc_o=0, inst=NOP_INST, inst_valid_o=0.
//   imem_req_o=0 while reset is high. The memory shares the reset and drops outstanding responses.
//  Redirect event: redir = (pcsel==PC_BRANCH) & ~StallFetch_i. While stalled, redirect is ignored. Decode re-presents it.
//  FSM:
//   S_REQ : imem_req_o=1, imem_addr_o=pc_f.
//           On redir: pc_f<=branch_tar. If ready in the same cycle, set kill=1 and go to S_WAIT.
//           Otherwise, on ready go to S_WAIT.
//           The address may change while req is high and not yet accepted.
//   S_WAIT: imem_req_o=0. On rvalid:
//           kill=1 -> drop data, kill<=0, go to S_REQ.
//           redir  -> drop data, pc_f<=branch_tar, go to S_REQ.
//           stall  -> capture {pc_f,rdata} into skid, go to S_HOLD.
//           else   -> IF/ID<={pc_f,rdata,1}, pc_f<=pc_f+4, go to S_REQ.
//           On redir without rvalid: pc_f<=branch_tar, kill<=1.
//   S_HOLD: imem_req_o=0.
//           redir  -> drop skid, pc_f<=branch_tar, go to S_REQ.
//           ~stall -> IF/ID<=skid with valid=1, pc_f<=pc_f+4, go to S_REQ.
//  IF/ID update rules:
//   - StallFetch_i=1: all IF/ID outputs hold.
//   - Not stalled, no instruction delivered (including any redir cycle): load bubble {pc_o holds, inst=NOP_INST, valid=0}.
//     This prevents decode from re-executing the previous instruction.
//  PC arithmetic: modulo 2^ADDR_LEN. 32'hFFFF_FFFC+4 wraps to 0. No alignment check.
//  Latency: min 2 cycles request-to-IF/ID with zero-wait memory. Steady-state throughput 1 instr / 2 cycles.
//  Simultaneous events: redir has priority over stall, which has priority over delivery. Reset has priority over everything.
// STRUCTURE
//  Shared package (core_defs): PC_PLUS4/PC_BRANCH, NOP_INST, fetch state encoding (S_REQ/S_WAIT/S_HOLD).
//   Decode uses the same pcsel encodings.
//  Sub-module if_id_reg: {pc,inst,valid} register with stall-hold and bubble-load inputs.
//  FSM, pc_f, kill and skid stay inline.
// TESTING
//  1 Reset, then zero-wait memory returning rdata=addr^32'hA5A5_0000 ->
//    IF/ID shows pc 0,4,8 on every 2nd cycle with valid=1, and NOP_INST/valid=0 in between.
//  2 Stall high for 3 cycles while in S_WAIT, rvalid arrives ->
//    IF/ID frozen, data held in skid, delivered on the first unstalled cycle, pc_f advances by 4 only once.
//  3 pcsel=PC_BRANCH, branch_tar=32'h100 in S_WAIT, rvalid 2 cycles later ->
//    stale response dropped, next req addr=32'h100, IF/ID bubble in between.
//  4 Redirect in S_REQ coinciding with imem_ready_i=1 (addr 8) ->
//    response for 8 discarded via kill, following req addr=branch_tar.
//  5 pcsel=PC_BRANCH while StallFetch_i=1 ->
//    no PC change; redirect taken in the first unstalled cycle.
//  6 reset asserted in S_HOLD with skid full ->
//    next cycle imem_req_o=0, inst=NOP_INST, valid=0; first req after release is RESET_PC.

Source files
------------

// File: rtl/core_defs.sv
// rtl/core_defs.sv - shared core encodings: pcsel codes, bubble instruction, fetch FSM states
package core_defs;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [1:0] S_REQ  = 2'b00;
    localparam logic [1:0] S_WAIT = 2'b01;
    localparam logic [1:0] S_HOLD = 2'b10;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with stall-hold and bubble-load
module if_id_reg #(
    parameter int                  WIDTH    = 32,
    parameter int                  ADDR_LEN = 32,
    parameter logic [WIDTH-1:0]    NOP_INST = core_defs::NOP_INST
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                load,
    input  logic [ADDR_LEN-1:0] pc_in,
    input  logic [WIDTH-1:0]    inst_in,
    output logic [ADDR_LEN-1:0] pc,
    output logic [WIDTH-1:0]    inst,
    output logic                valid
);

    // A non-load, non-stall cycle keeps pc but inserts a bubble so decode
    // never sees the previous instruction twice.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= '0;
            inst  <= NOP_INST;
            valid <= 1'b0;
        end else if (!stall) begin
            if (load) begin
                pc    <= pc_in;
                inst  <= inst_in;
                valid <= 1'b1;
            end else begin
                inst  <= NOP_INST;
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch stage: fetch PC, imem handshake, redirect and stall handling
module fetch #(
    parameter int                  WIDTH    = 32,
    parameter int                  ADDR_LEN = 32,
    parameter logic [ADDR_LEN-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0]    NOP_INST = core_defs::NOP_INST
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          pcsel,
    input  logic [ADDR_LEN-1:0] branch_tar,
    input  logic                StallFetch_i,
    output logic                imem_req_o,
    output logic [ADDR_LEN-1:0] imem_addr_o,
    input  logic                imem_ready_i,
    input  logic                imem_rvalid_i,
    input  logic [WIDTH-1:0]    imem_rdata_i,
    output logic [ADDR_LEN-1:0] pc_o,
    output logic [WIDTH-1:0]    inst,
    output logic                inst_valid_o
);
    import core_defs::*;

    logic [1:0]          state;
    logic [ADDR_LEN-1:0] pc_f;
    logic                kill;
    logic [ADDR_LEN-1:0] skid_pc;
    logic [WIDTH-1:0]    skid_inst;

    logic                redir;
    logic                deliver;
    logic [ADDR_LEN-1:0] dl_pc;
    logic [WIDTH-1:0]    dl_inst;

    // A redirect seen during a stall is ignored; decode holds it until released.
    assign redir       = (pcsel == PC_BRANCH) && !StallFetch_i;
    assign imem_req_o  = (state == S_REQ) && !reset;
    assign imem_addr_o = pc_f;

    always_comb begin
        deliver = 1'b0;
        dl_pc   = pc_f;
        dl_inst = imem_rdata_i;
        case (state)
            S_WAIT: begin
                if (imem_rvalid_i && !kill && !redir && !StallFetch_i)
                    deliver = 1'b1;
            end
            S_HOLD: begin
                if (!redir && !StallFetch_i) begin
                    deliver = 1'b1;
                    dl_pc   = skid_pc;
                    dl_inst = skid_inst;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f      <= RESET_PC;
            state     <= S_REQ;
            kill      <= 1'b0;
            skid_pc   <= '0;
            skid_inst <= NOP_INST;
        end else begin
            case (state)
                S_REQ: begin
                    // Request already accepted for the old PC: its response must be dropped.
                    if (redir) begin
                        pc_f <= branch_tar;
                        if (imem_ready_i) begin
                            kill  <= 1'b1;
                            state <= S_WAIT;
                        end
                    end else if (imem_ready_i) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= S_REQ;
                            if (redir)
                                pc_f <= branch_tar;
                        end else if (redir) begin
                            pc_f  <= branch_tar;
                            state <= S_REQ;
                        end else if (StallFetch_i) begin
                            skid_pc   <= pc_f;
                            skid_inst <= imem_rdata_i;
                            state     <= S_HOLD;
                        end else begin
                            pc_f  <= pc_f + ADDR_LEN'(4);
                            state <= S_REQ;
                        end
                    end else if (redir) begin
                        pc_f <= branch_tar;
                        kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redir) begin
                        pc_f  <= branch_tar;
                        state <= S_REQ;
                    end else if (!StallFetch_i) begin
                        pc_f  <= pc_f + ADDR_LEN'(4);
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    if_id_reg #(
        .WIDTH    (WIDTH),
        .ADDR_LEN (ADDR_LEN),
        .NOP_INST (NOP_INST)
    ) u_if_id (
        .clk     (clk),
        .reset   (reset),
        .stall   (StallFetch_i),
        .load    (deliver),
        .pc_in   (dl_pc),
        .inst_in (dl_inst),
        .pc      (pc_o),
        .inst    (inst),
        .valid   (inst_valid_o)
    );

endmodule
